// File: rtl/card_pkg.sv
// Shared card types and constants for the blackjack hand stack.
// Provides card_value() for the optional hand sum (CARD_STACK_SUM_EN).
package card_pkg;

    localparam int CARD_W      = 8;
    localparam int STACK_DEPTH = 11;

    typedef logic [CARD_W-1:0] card_t;

    // Blackjack value of a card code: rank nibble, face ranks clamped to 10, ace counts 1.
    function automatic logic [3:0] card_value(input card_t c);
        return (c[3:0] > 4'd10) ? 4'd10 : c[3:0];
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge pulse generator; pulse is high for the cycle where sig rises.
// The delayed copy clears on reset, so a level already high at release counts as an edge.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic pulse
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= 1'b0;
        else        sig_q <= sig;
    end

    assign pulse = sig & ~sig_q;

endmodule

// File: rtl/card_stack.sv
// Ordered store of up to 11 card codes for one blackjack hand, pushed on rising save.
// Optional running hand_sum output enabled by defining CARD_STACK_SUM_EN.
module card_stack
    import card_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH,
    parameter int WIDTH = CARD_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             save,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out_0,
    output logic [WIDTH-1:0] data_out_1,
    output logic [WIDTH-1:0] data_out_2,
    output logic [WIDTH-1:0] data_out_3,
    output logic [WIDTH-1:0] data_out_4,
    output logic [WIDTH-1:0] data_out_5,
    output logic [WIDTH-1:0] data_out_6,
    output logic [WIDTH-1:0] data_out_7,
    output logic [WIDTH-1:0] data_out_8,
    output logic [WIDTH-1:0] data_out_9,
    output logic [WIDTH-1:0] data_out_10,
`ifdef CARD_STACK_SUM_EN
    output logic [7:0]       hand_sum,
`endif
    output logic [3:0]       count,
    output logic             full
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                        push;
    logic                        wr_en;
    logic [CNT_W-1:0]            cnt;
    logic [DEPTH-1:0][WIDTH-1:0] slot;

    edge_detect u_save_edge (
        .clk   (clk_i),
        .rst_n (rst_i),
        .sig   (save),
        .pulse (push)
    );

    // Pushes into a full stack are silently dropped.
    assign wr_en = push && (cnt != CNT_W'(DEPTH));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)     cnt <= '0;
        else if (wr_en) cnt <= cnt + 1'b1;
    end

    // Each slot captures only when it is the next free one, so written slots never change.
    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i)                          slot[k] <= '0;
            else if (wr_en && cnt == CNT_W'(k))  slot[k] <= data_in;
        end
    end

`ifdef CARD_STACK_SUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)     sum_q <= '0;
        else if (wr_en) sum_q <= sum_q + 8'(card_value(data_in));
    end

    assign hand_sum = sum_q;
`endif

    assign count       = 4'(cnt);
    assign full        = (cnt == CNT_W'(DEPTH));

    assign data_out_0  = slot[0];
    assign data_out_1  = slot[1];
    assign data_out_2  = slot[2];
    assign data_out_3  = slot[3];
    assign data_out_4  = slot[4];
    assign data_out_5  = slot[5];
    assign data_out_6  = slot[6];
    assign data_out_7  = slot[7];
    assign data_out_8  = slot[8];
    assign data_out_9  = slot[9];
    assign data_out_10 = slot[10];

endmodule

// File: tb/tb_card_stack.sv
// Self-checking bench for card_stack: constant vector table, corner sequences and
// randomized pushes/resets checked against a queue-based model of the hand.
module tb_card_stack;

    logic       clk_i;
    logic       rst_i;
    logic       save;
    logic [7:0] data_in;
    logic [3:0] count;
    logic       full;
    wire  [7:0] dout [11];
`ifdef CARD_STACK_SUM_EN
    logic [7:0] hand_sum;
`endif

    card_stack dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .save        (save),
        .data_in     (data_in),
        .data_out_0  (dout[0]),
        .data_out_1  (dout[1]),
        .data_out_2  (dout[2]),
        .data_out_3  (dout[3]),
        .data_out_4  (dout[4]),
        .data_out_5  (dout[5]),
        .data_out_6  (dout[6]),
        .data_out_7  (dout[7]),
        .data_out_8  (dout[8]),
        .data_out_9  (dout[9]),
        .data_out_10 (dout[10]),
`ifdef CARD_STACK_SUM_EN
        .hand_sum    (hand_sum),
`endif
        .count       (count),
        .full        (full)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: the hand as an ordered list plus the previous save level.
    logic [7:0] q[$];
    bit         m_prev;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int card_val(input logic [7:0] d);
        int v;
        v = int'(d & 8'h0F);
        return (v > 10) ? 10 : v;
    endfunction

    task automatic check_model(input string tag);
        int s;
        s = 0;
        for (int k = 0; k < 11; k++) begin
            chk($sformatf("%s_slot%0d", tag, k), int'(dout[k]), (k < q.size()) ? int'(q[k]) : 0);
            if (k < q.size()) s += card_val(q[k]);
        end
        chk({tag, "_count"}, int'(count), q.size());
        chk({tag, "_full"},  int'(full),  (q.size() == 11) ? 1 : 0);
`ifdef CARD_STACK_SUM_EN
        chk({tag, "_sum"}, int'(hand_sum), s);
`endif
    endtask

    // Drive one cycle's inputs, advance past the edge, update the model, settle.
    task automatic cyc(input logic s, input logic [7:0] d);
        save    = s;
        data_in = d;
        @(posedge clk_i);
        if (rst_i) begin
            if (s && !m_prev && q.size() < 11) q.push_back(d);
            m_prev = s;
        end else begin
            m_prev = 1'b0;
        end
        #1;
    endtask

    // Assert reset between edges, check the clear is immediate, release between edges.
    task automatic do_reset(input string tag);
        @(negedge clk_i);
        #1 rst_i = 1'b0;
        q.delete();
        m_prev = 1'b0;
        #1 check_model({tag, "_async"});
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    typedef struct {
        bit         rst;
        bit         save;
        logic [7:0] data;
        int         cnt;
        int         full;
        int         top;
        int         sum;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1, 0, 8'h00, 0, 0, 8'h00, 0};
        tbl[1]  = '{0, 1, 8'h0A, 1, 0, 8'h0A, 10};
        tbl[2]  = '{0, 1, 8'h33, 1, 0, 8'h0A, 10};
        tbl[3]  = '{0, 1, 8'h44, 1, 0, 8'h0A, 10};
        tbl[4]  = '{0, 0, 8'h55, 1, 0, 8'h0A, 10};
        tbl[5]  = '{1, 0, 8'h00, 0, 0, 8'h00, 0};
        tbl[6]  = '{0, 1, 8'h05, 1, 0, 8'h05, 5};
        tbl[7]  = '{0, 0, 8'h00, 1, 0, 8'h05, 5};
        tbl[8]  = '{0, 1, 8'h0B, 2, 0, 8'h0B, 15};
        tbl[9]  = '{0, 0, 8'h00, 2, 0, 8'h0B, 15};
        tbl[10] = '{0, 1, 8'h01, 3, 0, 8'h01, 16};
        tbl[11] = '{0, 0, 8'hFF, 3, 0, 8'h01, 16};
        tbl[12] = '{0, 1, 8'h00, 4, 0, 8'h00, 16};
        tbl[13] = '{0, 0, 8'h00, 4, 0, 8'h00, 16};

        rst_i   = 1'b0;
        save    = 1'b0;
        data_in = 8'h00;
        m_prev  = 1'b0;

        #17 check_model("por");
        #5 rst_i = 1'b1;

        // Constant vector table.
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset($sformatf("tbl%0d", i));
            cyc(tbl[i].save, tbl[i].data);
            chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
            chk($sformatf("tbl%0d_full", i),  int'(full),  tbl[i].full);
            chk($sformatf("tbl%0d_top", i),
                int'(dout[(tbl[i].cnt > 0) ? tbl[i].cnt - 1 : 0]), tbl[i].top);
            if (tbl[i].cnt < 11)
                chk($sformatf("tbl%0d_next", i), int'(dout[tbl[i].cnt]), 0);
`ifdef CARD_STACK_SUM_EN
            chk($sformatf("tbl%0d_sum", i), int'(hand_sum), tbl[i].sum);
`endif
        end

        // Twelve pushes: the eleventh fills the stack, the twelfth is dropped.
        do_reset("fill");
        for (int v = 1; v <= 12; v++) begin
            cyc(1'b1, 8'(v));
            cyc(1'b0, 8'hEE);
        end
        for (int k = 0; k < 11; k++)
            chk($sformatf("fill_slot%0d", k), int'(dout[k]), k + 1);
        chk("fill_count", int'(count), 11);
        chk("fill_full",  int'(full),  1);
        check_model("fill");

        // Reset mid-stack, asynchronously between edges.
        do_reset("mid_pre");
        for (int v = 0; v < 5; v++) begin
            cyc(1'b1, 8'h30 + 8'(v));
            cyc(1'b0, 8'h00);
        end
        chk("mid_count_before", int'(count), 5);
        #2 rst_i = 1'b0;
        save    = 1'bx;
        data_in = 8'hxx;
        q.delete();
        m_prev = 1'b0;
        #1;
        chk("mid_count_clear", int'(count), 0);
        chk("mid_slot0_clear", int'(dout[0]), 0);
        chk("mid_slot4_clear", int'(dout[4]), 0);
        @(posedge clk_i);
        #1 chk("mid_x_count", int'(count), 0);
        save = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        cyc(1'b1, 8'h07);
        chk("mid_after_slot0", int'(dout[0]), 8'h07);
        chk("mid_after_count", int'(count), 1);
        cyc(1'b0, 8'h00);

        // save held high across reset release: exactly one push.
        save = 1'b1;
        do_reset("hold");
        cyc(1'b1, 8'h21);
        chk("hold_first_count", int'(count), 1);
        chk("hold_first_slot0", int'(dout[0]), 8'h21);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h22);
        chk("hold_stay_count", int'(count), 1);
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h23);
        chk("hold_next_slot1", int'(dout[1]), 8'h23);
        check_model("hold");

        // Randomized pushes and occasional resets against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 79) == 0) do_reset("rnd");
            cyc(1'($urandom_range(0, 1)), 8'($urandom));
            check_model("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
